// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg: shared sizes and FSM state encoding for the LDM/STM sequencer
package ldm_stm_sequencer_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int REG_FILE_DEPTH = 4;
    localparam int REG_FILE_SIZE = 16;
    localparam int ADDR_STEP = 4;
    typedef enum logic [1:0] {LSM_IDLE, LSM_ACCESS, LSM_DONE, LSM_WBASE} lsm_state_e;
endpackage

// File: rtl/ldm_stm_sequencer_priority_enc.sv
// lsm_priority_enc: index of the lowest set bit of a register mask, plus non-empty flag
module lsm_priority_enc #(
    parameter int SIZE = 16,
    parameter int DEPTH = 4
) (
    input  logic [SIZE-1:0]  mask,
    output logic [DEPTH-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx = '0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (mask[i]) idx = DEPTH'(i);
    end
    assign valid = |mask;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM block-transfer controller walking a register list lowest-first.
// Defining LSM_BASE_WRITEBACK_EN adds base_reg/wback ports and the WBASE base-register update.
module ldm_stm_sequencer #(
    parameter int WORD_WIDTH = ldm_stm_sequencer_pkg::WORD_WIDTH,
    parameter int REG_FILE_DEPTH = ldm_stm_sequencer_pkg::REG_FILE_DEPTH,
    parameter int REG_FILE_SIZE = ldm_stm_sequencer_pkg::REG_FILE_SIZE,
    parameter int ADDR_STEP = ldm_stm_sequencer_pkg::ADDR_STEP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      is_load,
    input  logic [REG_FILE_SIZE-1:0]  reg_list,
    input  logic [WORD_WIDTH-1:0]     base_addr,
`ifdef LSM_BASE_WRITEBACK_EN
    input  logic [REG_FILE_DEPTH-1:0] base_reg,
    input  logic                      wback,
`endif
    output logic                      busy,
    output logic                      stall,
    output logic                      done,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [WORD_WIDTH-1:0]     mem_addr,
    output logic [WORD_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ready,
    input  logic [WORD_WIDTH-1:0]     mem_rdata,
    output logic [REG_FILE_DEPTH-1:0] rf_src,
    input  logic [WORD_WIDTH-1:0]     rf_rdata,
    output logic                      rf_wb_en,
    output logic [REG_FILE_DEPTH-1:0] rf_wb_dest,
    output logic [WORD_WIDTH-1:0]     rf_wb_result
);
    import ldm_stm_sequencer_pkg::*;
    lsm_state_e state_q, state_d, fin_in, fin_q;
    logic load_q, valid, accept, step;
    logic [REG_FILE_SIZE-1:0] list_q, rest;
    logic [WORD_WIDTH-1:0] addr_q;
    logic [REG_FILE_DEPTH-1:0] idx;
    assign accept = state_q == LSM_IDLE && start;
    assign step = state_q == LSM_ACCESS && mem_ready;
    assign rest = list_q & (list_q - REG_FILE_SIZE'(1));
    lsm_priority_enc #(.SIZE(REG_FILE_SIZE), .DEPTH(REG_FILE_DEPTH)) u_enc (
        .mask(list_q),
        .idx(idx),
        .valid(valid)
    );
`ifdef LSM_BASE_WRITEBACK_EN
    logic [REG_FILE_DEPTH-1:0] base_reg_q;
    // a loaded base register keeps the loaded value, so WBASE is skipped then
    assign fin_in = wback && !(is_load && reg_list[base_reg]) ? LSM_WBASE : LSM_DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) base_reg_q <= '0;
        else if (accept) base_reg_q <= base_reg;
`else
    assign fin_in = LSM_DONE;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= LSM_IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSM_IDLE: if (start) state_d = |reg_list ? LSM_ACCESS : fin_in;
            LSM_ACCESS: if (mem_ready && rest == '0) state_d = fin_q;
            LSM_WBASE: state_d = LSM_DONE;
            default: state_d = LSM_IDLE;
        endcase
    end
    always_comb begin
        busy = state_q != LSM_IDLE;
        stall = busy;
        done = state_q == LSM_DONE;
        mem_req = state_q == LSM_ACCESS && valid;
        mem_we = mem_req && !load_q;
        mem_addr = mem_req ? addr_q : '0;
        rf_src = idx;
        mem_wdata = rf_rdata;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            load_q <= 1'b0;
            list_q <= '0;
            addr_q <= '0;
            fin_q <= LSM_DONE;
            rf_wb_en <= 1'b0;
            rf_wb_dest <= '0;
            rf_wb_result <= '0;
        end else begin
            rf_wb_en <= 1'b0;
            if (accept) begin
                load_q <= is_load;
                list_q <= reg_list;
                addr_q <= base_addr;
                fin_q <= fin_in;
            end
            if (step) begin
                list_q <= rest;
                addr_q <= addr_q + WORD_WIDTH'(ADDR_STEP);
                rf_wb_en <= load_q;
                rf_wb_dest <= idx;
                rf_wb_result <= mem_rdata;
            end
`ifdef LSM_BASE_WRITEBACK_EN
            // addr_q has advanced once per transfer, so it already holds the final base
            if (state_q == LSM_WBASE) begin
                rf_wb_en <= 1'b1;
                rf_wb_dest <= base_reg_q;
                rf_wb_result <= addr_q;
            end
`endif
        end
endmodule
